// File: rtl/relu_maxpool_4chanel_if.sv
// -----------------------------------------------------------------------------
// relu_maxpool_4chanel_if
//   Pixel-stream bundle for the 4-channel ReLU + 2x2 max-pool block.
//   Signals:
//     valid_in            - input beat qualifier (one pixel, all 4 channels)
//     data_in0..3         - IEEE-754 single conv results, raster order
//     valid_out           - one-cycle pulse per pooled pixel
//     data_out0..3        - pooled, rectified results
//     done_img            - pulses with the last valid_out of an image
//   Modports:
//     master - pixel producer (drives the inputs, observes the outputs)
//     slave  - the pooling block
// -----------------------------------------------------------------------------
interface relu_maxpool_4chanel_if;
  logic        valid_in;
  logic [31:0] data_in0;
  logic [31:0] data_in1;
  logic [31:0] data_in2;
  logic [31:0] data_in3;
  logic        valid_out;
  logic [31:0] data_out0;
  logic [31:0] data_out1;
  logic [31:0] data_out2;
  logic [31:0] data_out3;
  logic        done_img;

  modport master (
    output valid_in, data_in0, data_in1, data_in2, data_in3,
    input  valid_out, data_out0, data_out1, data_out2, data_out3, done_img
  );

  modport slave (
    input  valid_in, data_in0, data_in1, data_in2, data_in3,
    output valid_out, data_out0, data_out1, data_out2, data_out3, done_img
  );
endinterface

// File: rtl/relu_maxpool_4chanel.sv
// -----------------------------------------------------------------------------
// relu_maxpool_4chanel
//   Streaming ReLU followed by 2x2 / stride-2 max pooling on four parallel
//   channels of IEEE-754 single-precision pixels arriving in raster order.
//   Even columns park the rectified pixel in a holding register; odd columns
//   form the horizontal max. On even rows that max goes to a half-width line
//   buffer; on odd rows it is merged with the buffered value and registered
//   to the output (one cycle after the completing beat).
//   Ports:
//     clk    - clock, rising edge
//     resetn - asynchronous, active-low reset
//     bus    - relu_maxpool_4chanel_if.slave pixel stream in / pooled out
//   Parameters:
//     WIDTH, HEIGHT - input map size in pixels, both even and >= 2
// -----------------------------------------------------------------------------
module relu_maxpool_4chanel #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32
) (
  input logic                   clk,
  input logic                   resetn,
  relu_maxpool_4chanel_if.slave bus
);

  localparam int CW       = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam int RW       = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int LB_DEPTH = WIDTH / 2;
  localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [31:0]   r_hold [4];
  logic [31:0]   r_lb   [4][LB_DEPTH];
  logic [31:0]   r_dout [4];
  logic          r_valid_out;
  logic          r_done_img;

  logic [31:0]   w_din  [4];
  logic [31:0]   w_rect [4];
  logic [31:0]   w_hmax [4];
  logic [31:0]   w_lbrd [4];
  logic [31:0]   w_pool [4];
  logic [LW-1:0] w_lb_idx;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_odd_col;
  logic          w_odd_row;

  assign w_din[0] = bus.data_in0;
  assign w_din[1] = bus.data_in1;
  assign w_din[2] = bus.data_in2;
  assign w_din[3] = bus.data_in3;

  assign w_col_last = (r_col == CW'(WIDTH - 1));
  assign w_row_last = (r_row == RW'(HEIGHT - 1));
  assign w_odd_col  = r_col[0];
  assign w_odd_row  = r_row[0];
  assign w_lb_idx   = LW'(r_col >> 1);

  // After rectification bit 31 is always 0, so comparing bits 30:0 as an
  // unsigned integer orders non-negative floats (incl. inf/NaN) correctly.
  for (genvar c = 0; c < 4; c++) begin : g_chan
    assign w_rect[c] = w_din[c][31] ? 32'h0000_0000 : w_din[c];
    assign w_hmax[c] = (w_rect[c][30:0] > r_hold[c][30:0]) ? w_rect[c] : r_hold[c];
    assign w_lbrd[c] = r_lb[c][w_lb_idx];
    assign w_pool[c] = (w_hmax[c][30:0] > w_lbrd[c][30:0]) ? w_hmax[c] : w_lbrd[c];
  end

  // Position counters; row wrap starts the next image with no idle cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Holding registers capture the even-column pixel of each pair.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < 4; c++) r_hold[c] <= '0;
    end else if (bus.valid_in && !w_odd_col) begin
      for (int c = 0; c < 4; c++) r_hold[c] <= w_rect[c];
    end
  end

  // NOTE: the line buffer is a memory and deliberately has no reset: every
  // entry is rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (bus.valid_in && w_odd_col && !w_odd_row) begin
      for (int c = 0; c < 4; c++) r_lb[c][w_lb_idx] <= w_hmax[c];
    end
  end

  // Output stage: data holds its last pooled value; strobes are single-cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < 4; c++) r_dout[c] <= '0;
      r_valid_out <= 1'b0;
      r_done_img  <= 1'b0;
    end else if (bus.valid_in && w_odd_col && w_odd_row) begin
      for (int c = 0; c < 4; c++) r_dout[c] <= w_pool[c];
      r_valid_out <= 1'b1;
      r_done_img  <= w_col_last && w_row_last;
    end else begin
      r_valid_out <= 1'b0;
      r_done_img  <= 1'b0;
    end
  end

  assign bus.data_out0 = r_dout[0];
  assign bus.data_out1 = r_dout[1];
  assign bus.data_out2 = r_dout[2];
  assign bus.data_out3 = r_dout[3];
  assign bus.valid_out = r_valid_out;
  assign bus.done_img  = r_done_img;

endmodule

// File: doc/relu_maxpool_4chanel.md
RELU_MAXPOOL_4CHANEL -- requirements
Module: relu_maxpool_4chanel

Interface
REQ-001 Parameter WIDTH, default 32, input feature-map width in pixels; SHALL be even and >= 2.
REQ-002 Parameter HEIGHT, default 32, input feature-map height in pixels; SHALL be even and >= 2.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  input beat qualifier; one pixel of all 4 channels per asserted cycle.
REQ-006 data_in0..data_in3  input  32 each  IEEE-754 single conv results of filters 0..3, raster order (row-major, column 0 first).
REQ-007 data_out0..data_out3  output  32 each  pooled, rectified results of channels 0..3.
REQ-008 valid_out  output  1  data_out0..3 qualifier; one-cycle pulse per pooled pixel.
REQ-009 done_img  output  1  one-cycle pulse, coincident with the last valid_out of an image.

Function
REQ-010 Rectify: each input word with bit 31 = 1 (including -0.0) SHALL be replaced by 32'h0000_0000; otherwise passed unchanged.
REQ-011 Compare: after rectification all operands are non-negative; max SHALL be a 31-bit unsigned compare of bits 30:0; ties select either (equal value).
REQ-012 Input position SHALL be tracked by column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), advancing only on valid_in = 1.
REQ-013 col SHALL wrap to 0 after WIDTH-1 and increment row; row SHALL wrap to 0 after HEIGHT-1 with col wrap, starting the next image with no idle cycle required.
REQ-014 valid_in = 0 cycles SHALL hold all counters, buffers and holding registers; gaps of any length are legal anywhere in the image.
REQ-015 Even col: rectified pixel SHALL be stored per channel in a holding register.
REQ-016 Odd col: horizontal max hmax = max(holding, current rectified pixel) SHALL be formed per channel.
REQ-017 Even row, odd col: hmax SHALL be written to line buffer entry col/2 (WIDTH/2 entries x 32 bits per channel); no output.
REQ-018 Odd row, odd col: pooled value = max(hmax, line buffer[col/2]) SHALL be registered to data_outN with valid_out = 1 on the next rising edge (latency 1 cycle from the completing input beat).
REQ-019 valid_out SHALL be 0 in every cycle not covered by REQ-018; data_outN SHALL hold the last pooled value while valid_out = 0.
REQ-020 Exactly (WIDTH/2)*(HEIGHT/2) valid_out pulses SHALL occur per image, in raster order of the pooled map.
REQ-021 done_img SHALL be 1 in the same cycle as the valid_out produced by input (row HEIGHT-1, col WIDTH-1), else 0.
REQ-022 Back-to-back images: the first beat of image n+1 in the cycle after the last beat of image n SHALL be accepted; done_img of image n and line-buffer writes of image n+1 SHALL not interfere.
REQ-023 Line buffer contents SHALL not require clearing between images; every entry is written on an even row before being read on the following odd row.
REQ-024 The block has no backpressure; it SHALL accept valid_in every cycle.

Reset
REQ-025 resetn = 0 SHALL asynchronously set col = 0, row = 0, holding registers = 0, data_out0..3 = 0, valid_out = 0, done_img = 0.
REQ-026 Line buffer contents need not be reset.
REQ-027 Reset asserted mid-image SHALL discard the partial image; the first valid_in after resetn rises is pixel (0,0) of a new image.

Verification (WIDTH=4, HEIGHT=4 unless stated)
REQ-028 Ramp: channel 0 pixels = 1.0..16.0 raster, continuous valid_in -> 4 outputs 6.0, 8.0, 14.0, 16.0; done_img with the 4th, 1 cycle after the 16th input beat.
REQ-029 ReLU: window all negative (e.g. -1.0, -2.0, -0.0, -3.0) -> 32'h0; mixed window {-5.0, 0.5, -7.0, 0.25} -> 0.5; per-channel independence checked with 4 distinct patterns.
REQ-030 Gaps: same stimulus as REQ-028 with random valid_in deassertion (0-5 cycles) -> identical output sequence, each valid_out exactly 1 cycle after its completing beat.
REQ-031 Back-to-back: two images with no gap, second image = ramp negated then +100.0 offset pattern -> 8 outputs, 2 done_img pulses, no cross-image contamination.
REQ-032 Reset mid-image: assert resetn = 0 after 7 beats, release, send full ramp -> outputs 6.0, 8.0, 14.0, 16.0 only; all outputs 0 during reset.
REQ-033 Default parameters 32x32, random floats -> 256 outputs matching software ReLU+2x2 maxpool model, one done_img.
